landing_judge: RTL and testbench

LANDING_JUDGE -- requirements
Module: landing_judge

---
 rtl/landing_pkg.sv | 24 ++
 rtl/landing_judge_stage_hit_cmp.sv | 34 +++
 rtl/landing_judge.sv | 259 +++++++++++++++++++++++++
 tb/tb_landing_judge.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/landing_pkg.sv
// -----------------------------------------------------------------------------
// landing_pkg
// Shared definitions for the landing judge: FSM state encoding, default
// parameter values and the combo saturation limit.
// Optional feature macro used by the design: LANDING_JUDGE_COMBO_EN.
// -----------------------------------------------------------------------------
package landing_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EVAL   = 3'd1,
        ST_UPDATE = 3'd2,
        ST_REPORT = 3'd3,
        ST_DEAD   = 3'd4
    } state_t;

    localparam int DEF_NUM_STAGES = 2;
    localparam int DEF_COORD_W    = 10;
    localparam int DEF_CENTER_TOL = 10;
    localparam int DEF_SCORE_W    = 16;

    localparam logic [3:0] COMBO_MAX = 4'd15;

endpackage : landing_pkg

// File: rtl/landing_judge_stage_hit_cmp.sv
// -----------------------------------------------------------------------------
// stage_hit_cmp
// Combinational open-interval test: o_on = (center-half_w < man_x < center+half_w).
// Ports:
//   i_man_x  [COORD_W]  landing x
//   i_center [COORD_W]  platform (or window) centre x
//   i_half_w [COORD_W]  half-width of the interval
//   o_on                man_x strictly inside the interval
// -----------------------------------------------------------------------------
module stage_hit_cmp
    import landing_pkg::*;
#(
    parameter int COORD_W = DEF_COORD_W
)(
    input  logic [COORD_W-1:0] i_man_x,
    input  logic [COORD_W-1:0] i_center,
    input  logic [COORD_W-1:0] i_half_w,
    output logic               o_on
);

    // One sign bit plus one carry bit: centre-half_w can go negative and
    // centre+half_w can exceed the coordinate range, neither may wrap.
    localparam int EXT_W = COORD_W + 2;

    logic signed [EXT_W-1:0] w_man;
    logic signed [EXT_W-1:0] w_lo;
    logic signed [EXT_W-1:0] w_hi;

    assign w_man = signed'({2'b00, i_man_x});
    assign w_lo  = signed'({2'b00, i_center}) - signed'({2'b00, i_half_w});
    assign w_hi  = signed'({2'b00, i_center}) + signed'({2'b00, i_half_w});
    assign o_on  = (w_man > w_lo) && (w_man < w_hi);

endmodule : stage_hit_cmp

// File: rtl/landing_judge.sv
// -----------------------------------------------------------------------------
// landing_judge
// Judges a player landing against NUM_STAGES platforms, keeps score and a
// centre-hit combo, and reports the outcome through a valid/ready handshake.
// FSM: IDLE -> EVAL -> UPDATE -> REPORT -> IDLE (or DEAD on a miss).
// Optional feature: define LANDING_JUDGE_COMBO_EN for combo tracking with a
// 2*combo centre bonus; otherwise a centre hit scores a flat 2 and combo is 0.
// Ports:
//   clk, rst_n (sync, active-low)
//   land_valid/land_ready, man_x, stage_x[], stage_w[]  landing request
//   game_restart                                        clear game, back to IDLE
//   result_valid/result_ready                           result handshake
//   stage_idx, hit_center, game_over, score, combo      result fields
// -----------------------------------------------------------------------------
module landing_judge
    import landing_pkg::*;
#(
    parameter  int NUM_STAGES = DEF_NUM_STAGES,
    parameter  int COORD_W    = DEF_COORD_W,
    parameter  int CENTER_TOL = DEF_CENTER_TOL,
    parameter  int SCORE_W    = DEF_SCORE_W,
    localparam int IDX_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
)(
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                land_valid,
    output logic                                land_ready,
    input  logic [COORD_W-1:0]                  man_x,
    input  logic [NUM_STAGES-1:0][COORD_W-1:0]  stage_x,
    input  logic [NUM_STAGES-1:0][COORD_W-1:0]  stage_w,
    input  logic                                game_restart,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic [IDX_W-1:0]                    stage_idx,
    output logic                                hit_center,
    output logic                                game_over,
    output logic [SCORE_W-1:0]                  score,
    output logic [3:0]                          combo
);

    localparam logic [COORD_W-1:0] W_CENTER_TOL = COORD_W'(CENTER_TOL);

    // Saturating score increment; the extra top bit detects overflow.
    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a,
                                                   input logic [5:0]         b);
        logic [SCORE_W:0] sum;
        sum = {1'b0, a} + (SCORE_W+1)'(b);
        if (sum[SCORE_W]) begin
            sat_add = {SCORE_W{1'b1}};
        end else begin
            sat_add = sum[SCORE_W-1:0];
        end
    endfunction

    state_t                             r_state;
    state_t                             w_state_nxt;
    logic                               r_land_ready;
    logic                               r_result_valid;
    logic [COORD_W-1:0]                 r_man_x;
    logic [NUM_STAGES-1:0][COORD_W-1:0] r_stage_x;
    logic [NUM_STAGES-1:0][COORD_W-1:0] r_stage_w;
    logic [IDX_W-1:0]                   r_stage_idx;
    logic                               r_hit_center;
    logic                               r_any_hit;
    logic                               r_game_over;
    logic [SCORE_W-1:0]                 r_score;
    logic [SCORE_W-1:0]                 w_score_nxt;
    logic                               w_accept;
    logic [NUM_STAGES-1:0]              w_on;
    logic                               w_any_hit;
    logic [IDX_W-1:0]                   w_sel_idx;
    logic [COORD_W-1:0]                 w_sel_x;
    logic                               w_center_on;
`ifdef LANDING_JUDGE_COMBO_EN
    logic [3:0]                         r_combo;
    logic [3:0]                         w_combo_nxt;
`endif

    // A restart in the same cycle as a request wins: the landing is dropped.
    assign w_accept = land_valid & r_land_ready & ~game_restart;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_stage
        stage_hit_cmp #(.COORD_W(COORD_W)) u_cmp (
            .i_man_x  (r_man_x),
            .i_center (r_stage_x[g]),
            .i_half_w (r_stage_w[g]),
            .o_on     (w_on[g])
        );
    end

    // Centre window is tested only on the platform that was selected.
    stage_hit_cmp #(.COORD_W(COORD_W)) u_center_cmp (
        .i_man_x  (r_man_x),
        .i_center (w_sel_x),
        .i_half_w (W_CENTER_TOL),
        .o_on     (w_center_on)
    );

    // Lowest-index platform hit wins: scan from the top so index 0 is written last.
    always_comb begin
        w_any_hit = 1'b0;
        w_sel_idx = {IDX_W{1'b0}};
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            if (w_on[i]) begin
                w_any_hit = 1'b1;
                w_sel_idx = IDX_W'(i);
            end else begin
                w_any_hit = w_any_hit;
            end
        end
        w_sel_x = r_stage_x[w_sel_idx];
    end

    // Next-state logic; game_restart overrides every state.
    always_comb begin
        w_state_nxt = r_state;
        if (game_restart) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        w_state_nxt = ST_EVAL;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_EVAL:   w_state_nxt = ST_UPDATE;
                ST_UPDATE: w_state_nxt = ST_REPORT;
                ST_REPORT: begin
                    if (result_ready && r_game_over) begin
                        w_state_nxt = ST_DEAD;
                    end else if (result_ready) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_state_nxt = ST_REPORT;
                    end
                end
                ST_DEAD:   w_state_nxt = ST_DEAD;
                default:   w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // Score/combo values applied when leaving UPDATE.
    always_comb begin
        w_score_nxt = r_score;
`ifdef LANDING_JUDGE_COMBO_EN
        w_combo_nxt = r_combo;
        if (!r_any_hit) begin
            w_score_nxt = r_score;
            w_combo_nxt = r_combo;
        end else if (r_hit_center) begin
            if (r_combo == COMBO_MAX) begin
                w_combo_nxt = COMBO_MAX;
            end else begin
                w_combo_nxt = r_combo + 4'd1;
            end
            w_score_nxt = sat_add(r_score, {1'b0, w_combo_nxt, 1'b0});
        end else begin
            w_combo_nxt = 4'd0;
            w_score_nxt = sat_add(r_score, 6'd1);
        end
`else
        if (!r_any_hit) begin
            w_score_nxt = r_score;
        end else if (r_hit_center) begin
            w_score_nxt = sat_add(r_score, 6'd2);
        end else begin
            w_score_nxt = sat_add(r_score, 6'd1);
        end
`endif
    end

    // State register plus registered handshake flags derived from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_land_ready   <= 1'b1;
            r_result_valid <= 1'b0;
        end else begin
            r_state        <= w_state_nxt;
            r_land_ready   <= (w_state_nxt == ST_IDLE);
            r_result_valid <= (w_state_nxt == ST_REPORT);
        end
    end

    // Landing capture on an accepted request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_man_x   <= {COORD_W{1'b0}};
            r_stage_x <= '0;
            r_stage_w <= '0;
        end else if (w_accept) begin
            r_man_x   <= man_x;
            r_stage_x <= stage_x;
            r_stage_w <= stage_w;
        end else begin
            r_man_x   <= r_man_x;
        end
    end

    // Evaluation results latched in EVAL.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stage_idx  <= {IDX_W{1'b0}};
            r_hit_center <= 1'b0;
            r_any_hit    <= 1'b0;
        end else if (game_restart) begin
            r_stage_idx  <= {IDX_W{1'b0}};
            r_hit_center <= 1'b0;
            r_any_hit    <= 1'b0;
        end else if (r_state == ST_EVAL) begin
            r_stage_idx  <= w_sel_idx;
            r_hit_center <= w_any_hit & w_center_on;
            r_any_hit    <= w_any_hit;
        end else begin
            r_any_hit    <= r_any_hit;
        end
    end

    // Score, combo and game-over updated in UPDATE; game_over holds through DEAD.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_score     <= {SCORE_W{1'b0}};
            r_game_over <= 1'b0;
`ifdef LANDING_JUDGE_COMBO_EN
            r_combo     <= 4'd0;
`endif
        end else if (game_restart) begin
            r_score     <= {SCORE_W{1'b0}};
            r_game_over <= 1'b0;
`ifdef LANDING_JUDGE_COMBO_EN
            r_combo     <= 4'd0;
`endif
        end else if (r_state == ST_UPDATE) begin
            r_score     <= w_score_nxt;
            r_game_over <= ~r_any_hit;
`ifdef LANDING_JUDGE_COMBO_EN
            r_combo     <= w_combo_nxt;
`endif
        end else begin
            r_score     <= r_score;
        end
    end

    assign land_ready   = r_land_ready;
    assign result_valid = r_result_valid;
    assign stage_idx    = r_stage_idx;
    assign hit_center   = r_hit_center;
    assign game_over    = r_game_over;
    assign score        = r_score;
`ifdef LANDING_JUDGE_COMBO_EN
    assign combo        = r_combo;
`else
    assign combo        = 4'd0;
`endif

endmodule : landing_judge

// File: tb/tb_landing_judge.sv
// -----------------------------------------------------------------------------
// tb_landing_judge
// Directed self-checking bench for landing_judge (default parameters).
// A behavioural scoring model predicts each result; a negedge monitor checks
// every reported result, and literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_landing_judge;
    import landing_pkg::*;

    localparam int CW   = 10;
    localparam int CTOL = 10;
`ifdef LANDING_JUDGE_COMBO_EN
    localparam int EXP_FIRST_COMBO = 1;
    localparam int EXP_SAT_COMBO   = 15;
`else
    localparam int EXP_FIRST_COMBO = 0;
    localparam int EXP_SAT_COMBO   = 0;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                land_valid;
    logic                land_ready;
    logic [CW-1:0]       man_x;
    logic [1:0][CW-1:0]  stage_x;
    logic [1:0][CW-1:0]  stage_w;
    logic                game_restart;
    logic                result_valid;
    logic                result_ready;
    logic [0:0]          stage_idx;
    logic                hit_center;
    logic                game_over;
    logic [15:0]         score;
    logic [3:0]          combo;

    int   n_cmp  = 0;
    int   n_fail = 0;
    logic exp_pending = 1'b0;
    int   e_idx;
    logic e_center;
    logic e_go;
    int   m_score = 0;
    int   m_combo = 0;

    landing_judge dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .land_valid   (land_valid),
        .land_ready   (land_ready),
        .man_x        (man_x),
        .stage_x      (stage_x),
        .stage_w      (stage_w),
        .game_restart (game_restart),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .stage_idx    (stage_idx),
        .hit_center   (hit_center),
        .game_over    (game_over),
        .score        (score),
        .combo        (combo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Game rules: open interval hit test, lowest platform wins, centre window
    // on the chosen platform, score and combo bookkeeping with saturation.
    task automatic model_land(input int man, input int x0, input int w0,
                              input int x1, input int w1);
        int xs[2];
        int ws[2];
        int hit;
        xs[0] = x0; xs[1] = x1; ws[0] = w0; ws[1] = w1;
        hit = -1;
        for (int i = 0; i < 2; i++) begin
            if (hit < 0 && man > xs[i] - ws[i] && man < xs[i] + ws[i]) hit = i;
        end
        if (hit < 0) begin
            e_go = 1'b1; e_center = 1'b0; e_idx = 0;
        end else begin
            e_go = 1'b0; e_idx = hit;
            e_center = (man > xs[hit] - CTOL) && (man < xs[hit] + CTOL);
            if (e_center) begin
`ifdef LANDING_JUDGE_COMBO_EN
                m_combo = (m_combo < 15) ? m_combo + 1 : 15;
                m_score = m_score + 2 * m_combo;
`else
                m_score = m_score + 2;
`endif
            end else begin
                m_score = m_score + 1;
                m_combo = 0;
            end
            if (m_score > 65535) m_score = 65535;
        end
        exp_pending = 1'b1;
    endtask

    // Result monitor: every reported result must match the model; no result
    // may appear when none is expected.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (!exp_pending) begin
                chk("spurious_result_valid", result_valid, 0);
            end else if (result_valid) begin
                chk("game_over", game_over, e_go);
                chk("hit_center", hit_center, e_center);
                if (!e_go) chk("stage_idx", stage_idx, e_idx);
                chk("score", score, m_score);
                chk("combo", combo, m_combo);
                chk("land_ready_in_report", land_ready, 0);
            end
        end
    end

    // One full landing: request, latency check, optional hold, then accept the result.
    task automatic land(input int man, input int x0, input int w0,
                        input int x1, input int w1, input int hold);
        int n;
        n = 0;
        while (!land_ready && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("ready_before_land", land_ready, 1);
        man_x = CW'(man);
        stage_x[0] = CW'(x0); stage_w[0] = CW'(w0);
        stage_x[1] = CW'(x1); stage_w[1] = CW'(w1);
        land_valid = 1'b1;
        model_land(man, x0, w0, x1, w1);
        @(posedge clk); #1;
        land_valid = 1'b0;
        n = 1;
        while (!result_valid && n < 10) begin
            @(posedge clk); #1; n++;
        end
        chk("latency", n, 3);
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            chk("hold_result_valid", result_valid, 1);
            chk("hold_land_ready", land_ready, 0);
        end
        result_ready = 1'b1;
        @(posedge clk); #1;
        result_ready = 1'b0;
        exp_pending  = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; land_valid = 1'b0; result_ready = 1'b0; game_restart = 1'b0;
        man_x = '0; stage_x = '0; stage_w = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_score", score, 0);
        chk("rst_combo", combo, 0);
        chk("rst_stage_idx", stage_idx, 0);
        chk("rst_hit_center", hit_center, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_result_valid", result_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_land_ready", land_ready, 1);

        // Centre hit on platform 0.
        land(100, 100, 20, 300, 30, 0);
        chk("lit_first_score", score, 2);
        chk("lit_first_center", hit_center, 1);
        chk("lit_first_idx", stage_idx, 0);
        chk("lit_first_combo", combo, EXP_FIRST_COMBO);
        // Plain hit on platform 1.
        land(275, 100, 20, 300, 30, 0);
        chk("lit_second_score", score, 3);
        chk("lit_second_idx", stage_idx, 1);
        chk("lit_second_center", hit_center, 0);
        chk("lit_second_combo", combo, 0);
        // Bound arithmetic must not wrap at either end of the coordinate range.
        land(3, 5, 20, 300, 30, 0);
        chk("lit_underflow_idx", stage_idx, 0);
        chk("lit_underflow_go", game_over, 0);
        land(1020, 1015, 20, 300, 30, 0);
        chk("lit_overflow_go", game_over, 0);
        // Strict edge of platform 0 falls through to platform 1.
        land(120, 100, 20, 120, 5, 0);
        chk("lit_edge_idx", stage_idx, 1);
        // Overlap: platform 0 wins, centre judged on platform 0 only.
        land(110, 100, 20, 110, 50, 0);
        chk("lit_overlap_idx", stage_idx, 0);
        chk("lit_overlap_center", hit_center, 0);
        // Result held with result_ready low for 5 cycles.
        land(275, 100, 20, 300, 30, 5);
        // Sixteen consecutive centre hits.
        for (int i = 0; i < 16; i++) land(100, 100, 20, 300, 30, 0);
        chk("lit_combo_sat", combo, EXP_SAT_COMBO);

        // Miss both platforms -> DEAD, requests ignored.
        land(200, 100, 20, 300, 30, 0);
        chk("lit_miss_go", game_over, 1);
        land_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("dead_land_ready", land_ready, 0);
            chk("dead_game_over", game_over, 1);
        end
        land_valid = 1'b0;
        game_restart = 1'b1;
        @(posedge clk); #1;
        game_restart = 1'b0;
        m_score = 0; m_combo = 0;
        chk("restart_land_ready", land_ready, 1);
        chk("restart_score", score, 0);
        chk("restart_game_over", game_over, 0);
        chk("restart_combo", combo, 0);

        // Restart and request in the same IDLE cycle: restart wins.
        land_valid = 1'b1; game_restart = 1'b1;
        @(posedge clk); #1;
        land_valid = 1'b0; game_restart = 1'b0;
        chk("restart_vs_valid_ready", land_ready, 1);
        repeat (4) @(posedge clk);
        #1;
        chk("restart_vs_valid_idle", land_ready, 1);

        // Restart while a landing is in EVAL aborts it.
        land(275, 100, 20, 300, 30, 0);
        man_x = 10'd100; stage_x[0] = 10'd100; stage_w[0] = 10'd20;
        land_valid = 1'b1;
        @(posedge clk); #1;
        land_valid = 1'b0; game_restart = 1'b1;
        @(posedge clk); #1;
        game_restart = 1'b0;
        m_score = 0; m_combo = 0;
        chk("abort_land_ready", land_ready, 1);
        chk("abort_score", score, 0);
        repeat (5) @(posedge clk);
        #1;

        // Reset while a landing is in EVAL.
        land(100, 100, 20, 300, 30, 0);
        land_valid = 1'b1;
        @(posedge clk); #1;
        land_valid = 1'b0; rst_n = 1'b0;
        @(posedge clk); #1;
        m_score = 0; m_combo = 0;
        chk("evrst_result_valid", result_valid, 0);
        chk("evrst_score", score, 0);
        chk("evrst_combo", combo, 0);
        chk("evrst_hit_center", hit_center, 0);
        chk("evrst_stage_idx", stage_idx, 0);
        chk("evrst_game_over", game_over, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("evrst_land_ready", land_ready, 1);
        repeat (5) @(posedge clk);
        #1;
        land(275, 100, 20, 300, 30, 0);
        chk("post_reset_score", score, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_landing_judge
